// File: rtl/player_laser_pkg.sv
// Shared definitions for the player laser: state encoding, playfield constants
// and the saturating shot-count helper.
package player_laser_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_FLYING = 4'b0010,
        ST_HIT    = 4'b0100,
        ST_EXPIRE = 4'b1000
    } state_t;

    // Also used by the enemy grid collision check, so keep them in one place.
    localparam logic [9:0]  SPAWN_Y     = 10'd440;
    localparam logic [9:0]  TOP_BORDER  = 10'd24;
    localparam logic [9:0]  SPEED       = 10'd8;
    localparam logic [9:0]  LASER_H     = 10'd12;
    localparam logic [11:0] LASER_COLOR = 12'hFFF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/player_laser_if.sv
// Signal bundle between the player ship / enemy grid side and the laser block.
// fire_i is a request accepted only in IDLE with pause_i low; acceptance is seen
// as active_o=1 on the following cycle, and there is no separate ready signal.
interface player_laser_if;
    logic       frame_tick_i;
    logic       fire_i;
    logic [9:0] gun_pos_i;
    logic       pause_i;
    logic       hit_target_i;
    logic       clear_i;
    logic       active_o;
    logic [9:0] x_o;
    logic [9:0] y_top_o;
    logic [9:0] y_bot_o;
    logic       hit_o;
    logic       expired_o;
    logic [7:0] shots_o;
    logic [3:0] laser_red_o;
    logic [3:0] laser_green_o;
    logic [3:0] laser_blue_o;
    logic [3:0] state_o;

    modport master (
        output frame_tick_i, fire_i, gun_pos_i, pause_i, hit_target_i, clear_i,
        input  active_o, x_o, y_top_o, y_bot_o, hit_o, expired_o, shots_o,
               laser_red_o, laser_green_o, laser_blue_o, state_o
    );

    modport slave (
        input  frame_tick_i, fire_i, gun_pos_i, pause_i, hit_target_i, clear_i,
        output active_o, x_o, y_top_o, y_bot_o, hit_o, expired_o, shots_o,
               laser_red_o, laser_green_o, laser_blue_o, state_o
    );
endinterface

// File: rtl/laser_y_counter.sv
// 10-bit down-counter for the bullet top row: load has priority, and a step
// is only taken when it cannot wrap below zero.
module laser_y_counter
    import player_laser_pkg::*;
#(
    parameter logic [9:0] reset_val_p = SPAWN_Y,
    parameter logic [9:0] step_p      = SPEED
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       load_i,
    input  logic [9:0] load_val_i,
    input  logic       step_i,
    output logic [9:0] count_o
);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_o <= reset_val_p;
        end else if (load_i) begin
            count_o <= load_val_i;
        end else if (step_i && (count_o >= step_p)) begin
            count_o <= count_o - step_p;
        end
    end

endmodule

// File: rtl/player_laser.sv
// Single-bullet laser controller: fires from the gun x-position, climbs one
// step per frame tick, and retires on an enemy hit or at the top border.
module player_laser
    import player_laser_pkg::*;
#(
    parameter logic [11:0] color_p      = LASER_COLOR,
    parameter logic [9:0]  spawn_y_p    = SPAWN_Y,
    parameter logic [9:0]  top_border_p = TOP_BORDER,
    parameter logic [9:0]  speed_p      = SPEED,
    parameter logic [9:0]  laser_h_p    = LASER_H
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    player_laser_if.slave bus
);

    state_t     state_q, state_d;
    logic [9:0] x_q;
    logic [7:0] shots_q;
    logic [9:0] y_top;
    logic       y_load;
    logic       y_step;
    logic       fire_acc;

    laser_y_counter #(
        .reset_val_p (spawn_y_p),
        .step_p      (speed_p)
    ) u_y_counter (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .load_i     (y_load),
        .load_val_i (spawn_y_p),
        .step_i     (y_step),
        .count_o    (y_top)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            x_q     <= 10'd0;
            shots_q <= 8'd0;
        end else begin
            state_q <= state_d;
            if (fire_acc) begin
                x_q <= bus.gun_pos_i;
            end
            if (bus.clear_i) begin
                shots_q <= 8'd0;
            end else if (fire_acc) begin
                shots_q <= sat_inc8(shots_q);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        y_load   = 1'b0;
        y_step   = 1'b0;
        fire_acc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.fire_i && !bus.pause_i) begin
                    state_d  = ST_FLYING;
                    y_load   = 1'b1;
                    fire_acc = 1'b1;
                end
            end
            ST_FLYING: begin
                // While paused every flight input is ignored and the bullet holds.
                if (!bus.pause_i) begin
                    if (bus.hit_target_i) begin
                        state_d = ST_HIT;
                    end else if (bus.frame_tick_i) begin
                        if (y_top < top_border_p + speed_p) begin
                            state_d = ST_EXPIRE;
                        end else begin
                            y_step = 1'b1;
                        end
                    end
                end
            end
            ST_HIT:    state_d = ST_IDLE;
            ST_EXPIRE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (bus.clear_i) begin
            state_d  = ST_IDLE;
            y_load   = 1'b0;
            y_step   = 1'b0;
            fire_acc = 1'b0;
        end
    end

    assign bus.active_o      = (state_q == ST_FLYING);
    assign bus.hit_o         = (state_q == ST_HIT);
    assign bus.expired_o     = (state_q == ST_EXPIRE);
    assign bus.x_o           = x_q;
    assign bus.y_top_o       = y_top;
    assign bus.y_bot_o       = y_top + laser_h_p - 10'd1;
    assign bus.shots_o       = shots_q;
    assign bus.state_o       = state_q;
    assign bus.laser_red_o   = color_p[11:8];
    assign bus.laser_green_o = color_p[7:4];
    assign bus.laser_blue_o  = color_p[3:0];

endmodule

// File: doc/player_laser.md
# player_laser

Single-bullet controller for the player ship's laser. It accepts a fire request and gun x-position from the player ship, then advances the bullet upward one step per frame tick. It retires the bullet on an enemy hit or at the top border, reporting either outcome as a one-cycle pulse. It sits between the player ship and the enemy grid / score logic, and supplies position and colour to the display mux.

## Interface
- color_p, {4'hF, 4'hF, 4'hF}, laser colour in {Red,Green,Blue}
- spawn_y_p, 10'd440, y_top of a new bullet
- top_border_p, 10'd24, topmost legal y_top
- speed_p, 10'd8, pixels moved per frame tick
- laser_h_p, 10'd12, bullet height in pixels
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- frame_tick_i  in  1  one-cycle pulse per video frame
- fire_i  in  1  fire request (player shot_laser)
- gun_pos_i  in  10  player gun x, sampled on accepted fire
- pause_i  in  1  game frozen (player shot / dead)
- hit_target_i  in  1  collision reported by enemy grid
- clear_i  in  1  synchronous new-game/level clear
- active_o  out  1  bullet on screen
- x_o  out  10  bullet x (latched gun_pos_i)
- y_top_o  out  10  bullet top row
- y_bot_o  out  10  y_top_o + laser_h_p - 1
- hit_o  out  1  one-cycle pulse: bullet hit an enemy
- expired_o  out  1  one-cycle pulse: bullet left the top border
- shots_o  out  8  saturating count of accepted shots
- laser_red_o / laser_green_o / laser_blue_o  out  4 each  colour fields of color_p
- state_o  out  4  present state, for debug

## Operation
- One-hot states: IDLE=4'b0001, FLYING=4'b0010, HIT=4'b0100, EXPIRE=4'b1000. Any other encoding goes to IDLE on the next edge.
- IDLE: fire_i & ~pause_i → latch x=gun_pos_i, y_top=spawn_y_p, shots_o+1 (saturating at 255), go to FLYING. Otherwise stay.
- FLYING: hit_target_i & ~pause_i → HIT, y unchanged.
- FLYING, frame_tick_i & ~pause_i & ~hit_target_i:
  - if y_top < top_border_p + speed_p → EXPIRE
  - else y_top -= speed_p.
  - The comparison is made before subtracting, so y never wraps.
- FLYING with pause_i: position held. fire_i, hit_target_i and frame_tick_i are all ignored.
- fire_i outside IDLE is ignored; only one bullet exists at a time.
- HIT: hit_o=1 and active_o=0 for one cycle, then IDLE.
- EXPIRE: expired_o=1 and active_o=0 for one cycle, then IDLE.
- clear_i (any state) → IDLE, shots_o=0, no hit_o/expired_o pulse. clear_i has priority over every other input.
- active_o=1 only in FLYING. x_o/y_top_o hold their last values while inactive.
- All arithmetic is 10-bit unsigned.

## Timing
- Reset (asynchronous assert, synchronous release) values: state IDLE, active_o 0, x_o 0, y_top_o = spawn_y_p, y_bot_o = spawn_y_p + laser_h_p - 1, hit_o 0, expired_o 0, shots_o 0, state_o 4'b0001.
- Fire accepted at edge N → active_o=1 and y_top_o=spawn_y_p from cycle N+1.
- hit_target_i sampled at edge N → hit_o=1 and active_o=0 during cycle N+1.
- Re-fire is accepted at the earliest in the cycle after the hit_o/expired_o pulse, i.e. in IDLE.
- A frame tick moves y by exactly one step. A tick in the same cycle as fire acceptance does not move the bullet.
- Outputs are registered or decoded from state only, with no combinational path from inputs.

## Structure
- Shared package player_laser_pkg holds:
  - the state enum typedef
  - default border, speed and spawn constants, shared with the enemy grid collision check
- Sub-module laser_y_counter: 10-bit down-counter with load, async active-low reset and a guarded step. The existing counter block is not used because its reset is synchronous and active-high.
- The shot counter is inline.

## Test plan
- Reset, then fire_i with gun_pos_i=300 → next cycle active_o=1, x_o=300, y_top_o=440, y_bot_o=451, shots_o=1.
- Fire, then 52 frame ticks → y_top_o=24. The 53rd tick → expired_o for one cycle, active_o=0.
- Fire, 3 ticks (y_top_o=416), then hit_target_i together with frame_tick_i → hit_o for one cycle, y_top_o remains 416.
- fire_i held continuously for 10 cycles → shots_o=1. A second fire_i while FLYING is ignored.
- pause_i high for 5 ticks while FLYING → y_top_o unchanged and hit_target_i ignored. Release pause → movement resumes.
- clear_i mid-flight with shots_o=255 → IDLE, shots_o=0, no pulses. Async reset_n_i low mid-flight → outputs take their reset values immediately.
